// File: rtl/slow_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : slow_counter_pkg
//  Description : Shared BCD digit constants, direction encodings and clamp
//                helper for the multi-digit slow counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package slow_counter_pkg;

    localparam int              DIG_W   = 4;
    localparam logic [DIG_W-1:0] BCD_MAX = 4'd9;
    localparam logic [DIG_W-1:0] BCD_MIN = 4'd0;

    localparam logic UP   = 1'b0;
    localparam logic DOWN = 1'b1;

    // Any non-decimal nibble is forced to the largest legal digit.
    function automatic logic [DIG_W-1:0] bcd_clamp(input logic [DIG_W-1:0] v);
        return (v > BCD_MAX) ? BCD_MAX : v;
    endfunction

endpackage : slow_counter_pkg
`default_nettype wire

// File: rtl/bcd_digit.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit
//  Description : One BCD digit with load, up/down step and terminal flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit
    import slow_counter_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [DIG_W-1:0] d,
    output logic [DIG_W-1:0] q,
    output logic             at_term
);

    logic [DIG_W-1:0] digit_d;
    logic [DIG_W-1:0] digit_q;

    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = bcd_clamp(d);
        end else if (en) begin
            if (dir == UP) begin
                digit_d = (digit_q >= BCD_MAX) ? BCD_MIN : digit_q + 4'd1;
            end else begin
                digit_d = (digit_q == BCD_MIN) ? BCD_MAX : digit_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            digit_q <= BCD_MIN;
        end else begin
            digit_q <= digit_d;
        end
    end

    // Terminal means "the next step in this direction carries or borrows".
    assign at_term = (dir == UP) ? (digit_q == BCD_MAX) : (digit_q == BCD_MIN);
    assign q       = digit_q;

endmodule : bcd_digit
`default_nettype wire

// File: rtl/multi_digit_slow_counter.sv
`default_nettype none
// ============================================================================
//  Module      : multi_digit_slow_counter
//  Description : Cascaded BCD up/down counter with enable, load, wrap or
//                saturate at terminal count.
//  Revision    : 1.0 - initial release
// ============================================================================
module multi_digit_slow_counter
    import slow_counter_pkg::*;
#(
    parameter int DIGITS  = 3,
    parameter bit WRAP_EN = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    slowena,
    input  logic                    dir,
    input  logic                    load,
    input  logic [DIG_W*DIGITS-1:0] din,
    output logic [DIG_W*DIGITS-1:0] q,
    output logic [DIGITS-1:0]       ena,
    output logic                    tc
);

    logic [DIGITS-1:0] w_at_term;
    logic [DIGITS:0]   w_lower_term;
    logic              w_active;
    logic              w_step_ok;

    // w_lower_term[i] is set when every digit below i sits at its terminal.
    assign w_lower_term[0] = 1'b1;

    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_digit
            assign w_lower_term[i+1] = w_lower_term[i] & w_at_term[i];

            bcd_digit u_digit (
                .clk     (clk),
                .reset   (reset),
                .en      (ena[i]),
                .dir     (dir),
                .load    (load),
                .d       (din[DIG_W*i +: DIG_W]),
                .q       (q[DIG_W*i +: DIG_W]),
                .at_term (w_at_term[i])
            );
        end
    endgenerate

    assign w_active  = slowena & ~load & ~reset;
    assign tc        = w_active & w_lower_term[DIGITS];
    // Saturating variant freezes every digit once the terminal value is reached.
    assign w_step_ok = w_active & (WRAP_EN | ~w_lower_term[DIGITS]);
    assign ena       = w_lower_term[DIGITS-1:0] & {DIGITS{w_step_ok}};

endmodule : multi_digit_slow_counter
`default_nettype wire

// File: tb/tb_multi_digit_slow_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multi_digit_slow_counter
//  Description : Self-checking bench for wrapping and saturating 3-digit
//                counters against an integer-valued reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_digit_slow_counter;

    logic        clk = 1'b0;
    logic        reset, slowena, dir, load;
    logic [11:0] din;
    logic [11:0] q_w, q_s;
    logic [2:0]  ena_w, ena_s;
    logic        tc_w, tc_s;

    int checks = 0;
    int errors = 0;
    int mv_w   = 0;
    int mv_s   = 0;

    always #5 clk = ~clk;

    multi_digit_slow_counter #(.DIGITS(3), .WRAP_EN(1'b1)) u_dut_wrap (
        .clk(clk), .reset(reset), .slowena(slowena), .dir(dir), .load(load),
        .din(din), .q(q_w), .ena(ena_w), .tc(tc_w)
    );

    multi_digit_slow_counter #(.DIGITS(3), .WRAP_EN(1'b0)) u_dut_sat (
        .clk(clk), .reset(reset), .slowena(slowena), .dir(dir), .load(load),
        .din(din), .q(q_s), .ena(ena_s), .tc(tc_s)
    );

    // ---------------- reference model (decimal integer 0..999) ----------------
    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic int clamp_val(input logic [11:0] d);
        int r = 0;
        int scale = 1;
        for (int k = 0; k < 3; k++) begin
            int nib = int'(d[4*k +: 4]);
            r += ((nib > 9) ? 9 : nib) * scale;
            scale *= 10;
        end
        return r;
    endfunction

    function automatic int next_cnt(input int v, input logic d, input bit wrap);
        if (d == 1'b0) return (v == 999) ? (wrap ? 0 : 999) : v + 1;
        else           return (v == 0)   ? (wrap ? 999 : 0) : v - 1;
    endfunction

    function automatic logic [2:0] exp_ena(input int v, input bit wrap);
        logic [11:0] a, b;
        logic [2:0]  r;
        r = 3'b000;
        if (reset || load || !slowena) return r;
        a = to_bcd(v);
        b = to_bcd(next_cnt(v, dir, wrap));
        for (int k = 0; k < 3; k++) r[k] = (a[4*k +: 4] != b[4*k +: 4]);
        return r;
    endfunction

    function automatic logic exp_tc(input int v);
        return slowena && !load && !reset && (v == (dir ? 0 : 999));
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic set_in(input logic r, input logic l, input logic s,
                          input logic d, input logic [11:0] dn);
        @(negedge clk);
        reset = r; load = l; slowena = s; dir = d; din = dn;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset)        begin mv_w = 0;              mv_s = 0;              end
        else if (load)    begin mv_w = clamp_val(din); mv_s = clamp_val(din); end
        else if (slowena) begin mv_w = next_cnt(mv_w, dir, 1'b1);
                                mv_s = next_cnt(mv_s, dir, 1'b0); end
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 12'h123);
        checks++;
        if (tc_w !== 1'b0 || ena_w !== 3'b000) begin
            errors++; $display("FAIL reset_comb: tc=%b ena=%b want tc=0 ena=000", tc_w, ena_w);
        end
        tick();
        checks++;
        if (q_w !== 12'h000 || q_s !== 12'h000) begin
            errors++; $display("FAIL reset_q: q_w=%h q_s=%h want 000", q_w, q_s);
        end
    endtask

    task automatic test_up_carry();
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
        tick();
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
        for (int n = 0; n < 100; n++) begin
            if (n == 99) begin
                checks++;
                if (q_w !== 12'h099 || ena_w[2] !== 1'b1 || tc_w !== 1'b0) begin
                    errors++;
                    $display("FAIL up_carry_edge: q=%h ena=%b tc=%b want q=099 ena[2]=1 tc=0",
                             q_w, ena_w, tc_w);
                end
            end
            tick();
        end
        checks++;
        if (q_w !== 12'h100 || q_s !== 12'h100) begin
            errors++; $display("FAIL up_carry_q: q_w=%h q_s=%h want 100", q_w, q_s);
        end
    endtask

    task automatic test_wrap();
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 12'h999);
        tick();
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
        checks++;
        if (tc_w !== 1'b1 || ena_w !== 3'b111) begin
            errors++; $display("FAIL wrap_comb: tc=%b ena=%b want tc=1 ena=111", tc_w, ena_w);
        end
        checks++;
        if (tc_s !== 1'b1 || ena_s !== 3'b000) begin
            errors++; $display("FAIL sat_comb: tc=%b ena=%b want tc=1 ena=000", tc_s, ena_s);
        end
        tick();
        checks++;
        if (q_w !== 12'h000 || q_s !== 12'h999) begin
            errors++; $display("FAIL wrap_q: q_w=%h q_s=%h want 000/999", q_w, q_s);
        end
    endtask

    task automatic test_down_borrow();
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 12'h100);
        tick();
        set_in(1'b0, 1'b0, 1'b1, 1'b1, 12'h000);
        tick();
        checks++;
        if (q_w !== 12'h099) begin
            errors++; $display("FAIL down_borrow: q=%h want 099", q_w);
        end
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 12'h000);
        tick();
        set_in(1'b0, 1'b0, 1'b1, 1'b1, 12'h000);
        checks++;
        if (tc_w !== 1'b1) begin
            errors++; $display("FAIL down_tc: tc=%b want 1", tc_w);
        end
        tick();
        checks++;
        if (q_w !== 12'h999 || q_s !== 12'h000) begin
            errors++; $display("FAIL down_wrap: q_w=%h q_s=%h want 999/000", q_w, q_s);
        end
    endtask

    task automatic test_load_clamp();
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 12'h3A7);
        checks++;
        if (ena_w !== 3'b000 || tc_w !== 1'b0) begin
            errors++; $display("FAIL load_comb: ena=%b tc=%b want 000/0", ena_w, tc_w);
        end
        tick();
        checks++;
        if (q_w !== 12'h397) begin
            errors++; $display("FAIL load_clamp: q=%h want 397", q_w);
        end
    endtask

    task automatic test_slowena_gating();
        logic [3:0]  pat  = 4'b1001;
        logic [11:0] want [4] = '{12'h006, 12'h006, 12'h006, 12'h007};
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 12'h005);
        tick();
        for (int n = 0; n < 4; n++) begin
            set_in(1'b0, 1'b0, pat[3-n], 1'b0, 12'h000);
            tick();
            checks++;
            if (q_w !== want[n]) begin
                errors++; $display("FAIL gating_%0d: q=%h want %h", n, q_w, want[n]);
            end
        end
    endtask

    task automatic test_reset_dominance();
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 12'h099);
        tick();
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 12'h555);
        checks++;
        if (tc_w !== 1'b0 || ena_w !== 3'b000) begin
            errors++; $display("FAIL rst_dom_comb: tc=%b ena=%b want 0/000", tc_w, ena_w);
        end
        tick();
        checks++;
        if (q_w !== 12'h000) begin
            errors++; $display("FAIL rst_dom_q: q=%h want 000", q_w);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            set_in(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
                   ($urandom_range(0, 9) < 8), 1'($urandom_range(0, 1)),
                   12'($urandom));
            checks++;
            if (ena_w !== exp_ena(mv_w, 1'b1) || tc_w !== exp_tc(mv_w) ||
                ena_s !== exp_ena(mv_s, 1'b0) || tc_s !== exp_tc(mv_s)) begin
                errors++;
                $display("FAIL rand_comb_%0d: ena=%b/%b tc=%b/%b want ena=%b/%b tc=%b/%b", n,
                         ena_w, ena_s, tc_w, tc_s, exp_ena(mv_w, 1'b1), exp_ena(mv_s, 1'b0),
                         exp_tc(mv_w), exp_tc(mv_s));
            end
            tick();
            checks++;
            if (q_w !== to_bcd(mv_w) || q_s !== to_bcd(mv_s)) begin
                errors++;
                $display("FAIL rand_q_%0d: q=%h/%h want %h/%h", n, q_w, q_s,
                         to_bcd(mv_w), to_bcd(mv_s));
            end
        end
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; slowena = 1'b0; dir = 1'b0; din = 12'h000;
        test_reset();
        test_up_carry();
        test_wrap();
        test_down_borrow();
        test_load_clamp();
        test_slowena_gating();
        test_reset_dominance();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_multi_digit_slow_counter
`default_nettype wire

// File: doc/multi_digit_slow_counter.md
MULTI_DIGIT_SLOW_COUNTER -- requirements
Module: multi_digit_slow_counter

Interface
REQ-001 SHALL have parameter DIGITS, default 3, number of cascaded BCD digits (legal range 1..8).
REQ-002 SHALL have parameter WRAP_EN, default 1; 1 = wrap at terminal value, 0 = saturate at terminal value.
REQ-003 SHALL have port clk, input, 1 bit, sole clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have port slowena, input, 1 bit, count enable; the counter advances only on edges where it is high.
REQ-006 SHALL have port dir, input, 1 bit, count direction; 0 = up, 1 = down.
REQ-007 SHALL have port load, input, 1 bit, synchronous parallel-load strobe.
REQ-008 SHALL have port din, input, 4*DIGITS bits, load value; digit i is din[4i+3:4i].
REQ-009 SHALL have port q, output, 4*DIGITS bits, registered BCD count; digit 0 is the least significant.
REQ-010 SHALL have port ena, output, DIGITS bits, per-digit advance indication; ena[i]=1 when digit i changes on the next edge.
REQ-011 SHALL have port tc, output, 1 bit, terminal-count indication: the next edge reaches or passes the terminal value.

Function
REQ-012 Priority SHALL be: reset > load > slowena; dir is sampled only when counting.
REQ-013 On a load edge, each digit SHALL take its din value; any din digit greater than 9 SHALL be loaded as 9.
REQ-014 Up mode: digit 0 SHALL increment when slowena=1; digit i>0 SHALL increment only when slowena=1 and all lower digits equal 9.
REQ-015 Down mode: digit 0 SHALL decrement when slowena=1; digit i>0 SHALL decrement only when slowena=1 and all lower digits equal 0.
REQ-016 A digit SHALL step 9->0 (up) or 0->9 (down) when it carries or borrows, and SHALL never hold a value above 9.
REQ-017 The terminal value SHALL be all 9s in up mode and all 0s in down mode.
REQ-018 tc SHALL be combinational and equal to slowena & ~load & ~reset & (q == terminal value for the current dir).
REQ-019 With WRAP_EN=1 and tc=1, the next edge SHALL wrap q to all 0s (up) or all 9s (down).
REQ-020 With WRAP_EN=0 and tc=1, q SHALL hold; tc SHALL still assert; ena SHALL be all 0.
REQ-021 ena SHALL be combinational and SHALL be 0 whenever reset or load is high.
REQ-022 Changing dir between edges SHALL take effect on the next counting edge with no lost or extra step.
REQ-023 With slowena=0 and load=0, q SHALL hold indefinitely.
REQ-024 A count SHALL have single-edge latency: q reflects the step on the edge where slowena was sampled high.

Reset
REQ-025 While reset is high on an edge, q SHALL become all 0s regardless of load and slowena.
REQ-026 While reset is high, tc and ena SHALL read 0.
REQ-027 Reset asserted mid-carry (e.g. q=099 counting up) SHALL yield q=000 with no partial carry applied.

Structure
REQ-028 Package slow_counter_pkg SHALL hold the digit width constant DIG_W=4, the constants BCD_MAX=9 and BCD_MIN=0, and the direction encodings UP=0 and DOWN=1.
REQ-029 A sub-module bcd_digit SHALL implement one digit, with inputs clk, reset, en, dir, load, d and outputs q and at_term; the top SHALL instantiate DIGITS copies via generate.
REQ-030 The carry and borrow chain SHALL be built from at_term outputs using an AND-prefix; no clock gating or derived clocks SHALL be used.

Verification
REQ-031 Bench SHALL cover up-count carry: DIGITS=3, reset then slowena=1, dir=0, 100 edges -> q=100; ena[2]=1 and tc=0 on the edge 099->100.
REQ-032 Bench SHALL cover wrap: load 999, dir=0, slowena=1 -> tc=1 and ena=3'b111, then q=000 after one edge; with WRAP_EN=0, q stays 999.
REQ-033 Bench SHALL cover down-count borrow: load 100, dir=1, 1 edge -> q=099; from 000 -> tc=1, then q=999 (WRAP_EN=1).
REQ-034 Bench SHALL cover load priority and clamp: din=0x3A7 with load=1 and slowena=1 -> q=0x397 and ena=0 during load.
REQ-035 Bench SHALL cover slowena gating: toggle slowena 1,0,0,1 from q=005 with dir=0 -> q=006,006,006,007.
REQ-036 Bench SHALL cover reset dominance: reset=1 with load=1 and din=0x555 at q=099 -> q=000, tc=0, ena=0.
